seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the 8-bit switch-driven ALU: a W-bit sequential ALU with a valid/ready operand interface, a registered result and a condition-flag register. Single-cycle ops complete in one cycle; MUL, and DIV when compiled in, are iterative and take W cycles. It sits between the operand source (switches, or the future register file) and the result/flag consumers (seven-segment readout, LEDs, future branch logic).

## Interface
- W, default 8: operand/result width, W >= 4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept an op
- op  in  3  operation code (alu_op_e)
- a  in  W  operand A, two's complement
- b  in  W  operand B, two's complement
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  W  registered result
- flags  out  7  {err, z, n, vn, vp, br, c}, registered
- busy  out  1  high in MUL_RUN or DIV_RUN

## Operation
- Ops: 000 AND, 001 SUB (a-b), 010 ADD, 011 MUL (low W bits of product), 100 OR, 101 XOR, 110 DIV (unsigned a/b quotient, macro-gated), 111 reserved.
- FSM states: IDLE, MUL_RUN, DIV_RUN, DONE. in_ready = (state == IDLE). Accept on in_valid && in_ready; a, b, op captured at that edge.
- IDLE + accept: single-cycle op -> result/flags loaded, go DONE. MUL -> MUL_RUN; DIV -> DIV_RUN; 111 -> DONE, result 0, err=1.
- MUL_RUN: shift-add over W iterations on captured operands (low W bits identical for signed/unsigned); counter 0..W-1, then DONE.
- DIV_RUN: restoring unsigned division, W iterations, then DONE. b == 0: still W cycles, result all ones, err=1.
- DONE: out_valid=1; result/flags held stable until out_ready; on out_valid && out_ready go IDLE.
- Flags: z = (result == 0); n = result[W-1]; ADD: c = carry out of bit W-1, vp = signed overflow; SUB: br = borrow (a <u b), vn = signed overflow; c, br, vp, vn = 0 for all other ops. err = 0 except reserved op, divide by zero, or DIV with macro absent.

## Timing
- Reset (async, immediate): state IDLE, counter 0, result 0, flags 0, out_valid 0, busy 0; in_ready 1 once rst low. Reset mid-iteration discards the op, no partial output.
- Single-cycle op accepted at edge k: out_valid high after edge k+1.
- MUL/DIV accepted at edge k: busy high after k+1 through k+W; out_valid high after edge k+W+1.
- in_ready low from accept until the edge completing the output handshake; in_valid ignored while in_ready low.
- out_valid and out_ready same cycle: IDLE next edge, in_ready high next cycle (max one op per 2 cycles).

## Configuration
- SEQ_ALU_DIV_EN defined: op 110 performs iterative unsigned divide as above.
- Undefined: no divider logic; op 110 treated as reserved (one cycle, result 0, err=1). DIV_RUN state unreachable.

## Structure
- Package alu_pkg: alu_op_e (3-bit op enum), alu_state_e, flag bit-index constants (FLAG_C=0 .. FLAG_ERR=6).
- One sub-module, seq_alu_iter: W-bit iterative shift-add/restoring-divide datapath with start/done and counter; seq_alu holds FSM, single-cycle ops, flag logic and output registers.
- Seven-segment decode stays in the existing sevenseg module, outside this block.

## Test plan
- W=8, AND a=0xF5 b=0x3C -> result 0x34, flags 0, out_valid exactly 1 cycle after accept.
- ADD 0x7F+0x01 -> 0x80, vp=1, n=1, c=0; ADD 0xFF+0x01 -> 0x00, c=1, z=1, vp=0.
- SUB 0x00-0x01 -> 0xFF, br=1, n=1, vn=0; SUB 0x80-0x01 -> 0x7F, vn=1, br=0.
- MUL 0xFD*0x05 -> 0xF1, out_valid 9 cycles after accept, busy 8 cycles; hold out_ready low 3 cycles -> result stable, in_ready low, extra in_valid ignored.
- rst pulsed 4 cycles into MUL -> all outputs 0 immediately, in_ready 1 after release; next ADD 0x02+0x03 -> 0x05.
- With SEQ_ALU_DIV_EN: 0x64/0x07 -> 0x0E after 9 cycles; 0x10/0x00 -> 0xFF, err=1. Without: op 110 -> result 0, err=1 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states, flag indices.
// Op 110 (DIV) is only implemented when SEQ_ALU_DIV_EN is defined.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_SUB = 3'b001,
      OP_ADD = 3'b010,
      OP_MUL = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_DIV = 3'b110,
      OP_RSV = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL_RUN,
      ST_DIV_RUN,
      ST_DONE
   } alu_state_e;

   localparam int FLAG_C   = 0;
   localparam int FLAG_BR  = 1;
   localparam int FLAG_VP  = 2;
   localparam int FLAG_VN  = 3;
   localparam int FLAG_N   = 4;
   localparam int FLAG_Z   = 5;
   localparam int FLAG_ERR = 6;
   localparam int FLAG_W   = 7;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// master = operand source and result consumer, slave = the ALU.
interface seq_alu_if
   import alu_pkg::*;
#(
   parameter int W = 8
) ();

   logic              in_valid;
   logic              in_ready;
   alu_op_e           op;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      result;
   logic [FLAG_W-1:0] flags;
   logic              busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flags, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flags, busy
   );

endinterface

// File: rtl/seq_alu_iter.sv
// W-iteration datapath: shift-add multiply, and restoring unsigned
// divide when SEQ_ALU_DIV_EN is defined.
module seq_alu_iter
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic         div_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         last_o,
   output logic [W-1:0] res_o
);

   localparam int CW = $clog2(W);

   // acc: product / remainder; opa: multiplicand / quotient;
   // opb: multiplier / divisor
   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  opa_q, opa_d;
   logic [W-1:0]  opb_q, opb_d;
   logic          div_q, div_d;

   assign last_o = run_q && (cnt_q == CW'(W - 1));

`ifdef SEQ_ALU_DIV_EN
   logic [W:0]   shifted;
   logic [W-1:0] trial;
   logic         ge;

   assign res_o = div_q ? opa_q : acc_q;
`else
   logic unused_div;

   assign unused_div = div_i;
   assign res_o      = acc_q;
`endif

   // One iteration per cycle while running; operands loaded on start
   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      opa_d = opa_q;
      opb_d = opb_q;
      div_d = div_q;
`ifdef SEQ_ALU_DIV_EN
      shifted = {acc_q, opa_q[W-1]};
      ge      = (shifted >= {1'b0, opb_q});
      trial   = shifted[W-1:0] - opb_q;
`endif
      if (start_i) begin
         run_d = 1'b1;
         cnt_d = '0;
         acc_d = '0;
         opa_d = a_i;
         opb_d = b_i;
`ifdef SEQ_ALU_DIV_EN
         div_d = div_i;
`else
         div_d = 1'b0;
`endif
      end else if (run_q) begin
         cnt_d = last_o ? '0 : cnt_q + CW'(1);
         run_d = !last_o;
`ifdef SEQ_ALU_DIV_EN
         if (div_q) begin
            acc_d = ge ? trial : shifted[W-1:0];
            opa_d = {opa_q[W-2:0], ge};
         end else begin
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
         end
`else
         if (opb_q[0]) acc_d = acc_q + opa_q;
         opa_d = opa_q << 1;
         opb_d = opb_q >> 1;
`endif
      end
   end

   // Iteration state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         acc_q <= '0;
         opa_q <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         opa_q <= opa_d;
         opb_q <= opb_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// W-bit sequential ALU: FSM, single-cycle ops, flags, output registers.
// Define SEQ_ALU_DIV_EN to build the iterative unsigned divider.
module seq_alu
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic     clk,
   input  logic     rst,
   seq_alu_if.slave bus
);

   alu_state_e        state_q, state_d;
   alu_op_e           op_q, op_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic [W-1:0]      result_q, result_d;
   logic [FLAG_W-1:0] flags_q, flags_d;

   logic              in_ready;
   logic              accept;
   logic              is_div;
   logic              iter_start;
   logic              iter_last;
   logic [W-1:0]      iter_res;
   logic [W:0]        sum;
   logic [W:0]        diff;
   logic [W-1:0]      calc_res;
   logic [FLAG_W-1:0] calc_flags;

   assign in_ready   = (state_q == ST_IDLE) && !rst;
   assign accept     = bus.in_valid && in_ready;
`ifdef SEQ_ALU_DIV_EN
   assign is_div     = (bus.op == OP_DIV);
`else
   assign is_div     = 1'b0;
`endif
   assign iter_start = accept && ((bus.op == OP_MUL) || is_div);

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

   seq_alu_iter #(
      .W (W)
   ) u_iter (
      .clk     (clk),
      .rst     (rst),
      .start_i (iter_start),
      .div_i   (is_div),
      .a_i     (bus.a),
      .b_i     (bus.b),
      .last_o  (iter_last),
      .res_o   (iter_res)
   );

   // Result and flags from the captured operands
   always_comb begin
      sum        = {1'b0, a_q} + {1'b0, b_q};
      diff       = {1'b0, a_q} - {1'b0, b_q};
      calc_res   = '0;
      calc_flags = '0;
      unique case (op_q)
         OP_AND: calc_res = a_q & b_q;
         OP_OR:  calc_res = a_q | b_q;
         OP_XOR: calc_res = a_q ^ b_q;
         OP_MUL: calc_res = iter_res;
         OP_ADD: begin
            calc_res           = sum[W-1:0];
            calc_flags[FLAG_C] = sum[W];
            calc_flags[FLAG_VP] = (a_q[W-1] == b_q[W-1]) &&
                                  (sum[W-1] != a_q[W-1]);
         end
         OP_SUB: begin
            calc_res            = diff[W-1:0];
            calc_flags[FLAG_BR] = diff[W];
            calc_flags[FLAG_VN] = (a_q[W-1] != b_q[W-1]) &&
                                  (diff[W-1] != a_q[W-1]);
         end
`ifdef SEQ_ALU_DIV_EN
         OP_DIV: begin
            calc_res             = iter_res;
            calc_flags[FLAG_ERR] = (b_q == '0);
         end
`endif
         default: calc_flags[FLAG_ERR] = 1'b1;
      endcase
      calc_flags[FLAG_Z] = (calc_res == '0);
      calc_flags[FLAG_N] = calc_res[W-1];
   end

   // Control FSM: next state, operand capture, output loading
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      flags_d     = flags_q;
      busy_d      = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
      out_valid_d = (state_q == ST_DONE) &&
                    !(out_valid_q && bus.out_ready);
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d = bus.op;
               a_d  = bus.a;
               b_d  = bus.b;
               if (bus.op == OP_MUL) state_d = ST_MUL_RUN;
               else if (is_div)      state_d = ST_DIV_RUN;
               else                  state_d = ST_DONE;
            end
         end
         ST_MUL_RUN,
         ST_DIV_RUN: begin
            if (iter_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!out_valid_q) begin
               result_d = calc_res;
               flags_d  = calc_flags;
            end else if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_AND;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at W=8, table vectors plus
// handshake-hold and mid-multiply reset sequences.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   seq_alu_if #(.W(8)) bus ();

   seq_alu #(.W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      alu_op_e    op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [6:0] fl;
      int         lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issue one op and wait for out_valid; lat = cycles after accept
   task automatic run_op(input alu_op_e op, input logic [7:0] a,
                         input logic [7:0] b, output int lat,
                         output int bcnt);
      lat  = -1;
      bcnt = 0;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.busy) bcnt++;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic finish_op(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({name, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int bcnt;
      int seen;

      n_cmp = 0;
      n_bad = 0;

      vecs.push_back('{OP_AND, 8'hF5, 8'h3C, 8'h34, 7'h00, 1});
      vecs.push_back('{OP_ADD, 8'h7F, 8'h01, 8'h80, 7'h14, 1});
      vecs.push_back('{OP_ADD, 8'hFF, 8'h01, 8'h00, 7'h21, 1});
      vecs.push_back('{OP_SUB, 8'h00, 8'h01, 8'hFF, 7'h12, 1});
      vecs.push_back('{OP_SUB, 8'h80, 8'h01, 8'h7F, 7'h08, 1});
      vecs.push_back('{OP_OR,  8'h50, 8'h0A, 8'h5A, 7'h00, 1});
      vecs.push_back('{OP_XOR, 8'hFF, 8'h0F, 8'hF0, 7'h10, 1});
      vecs.push_back('{OP_MUL, 8'hFD, 8'h05, 8'hF1, 7'h10, 9});
      vecs.push_back('{OP_MUL, 8'h10, 8'h10, 8'h00, 7'h20, 9});
      vecs.push_back('{OP_RSV, 8'h11, 8'h22, 8'h00, 7'h60, 1});
`ifdef SEQ_ALU_DIV_EN
      vecs.push_back('{OP_DIV, 8'h64, 8'h07, 8'h0E, 7'h00, 9});
      vecs.push_back('{OP_DIV, 8'h10, 8'h00, 8'hFF, 7'h50, 9});
`else
      vecs.push_back('{OP_DIV, 8'h64, 8'h07, 8'h00, 7'h60, 1});
`endif

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = OP_AND;
      bus.a         = '0;
      bus.b         = '0;

      #12;
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_flags", 32'(bus.flags), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_ready", 32'(bus.in_ready), 32'd1);

      foreach (vecs[i]) begin
         string nm;
         nm = $sformatf("v%0d_%s", i, vecs[i].op.name());
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
         chk({nm, "_lat"}, 32'(lat), 32'(vecs[i].lat));
         chk({nm, "_res"}, 32'(bus.result), 32'(vecs[i].res));
         chk({nm, "_flags"}, 32'(bus.flags), 32'(vecs[i].fl));
         if (vecs[i].lat > 1)
            chk({nm, "_busy_cyc"}, 32'(bcnt), 32'(vecs[i].lat - 1));
         finish_op(nm);
      end

      // Multiply, then hold the result while new operands knock
      run_op(OP_MUL, 8'hFD, 8'h05, lat, bcnt);
      chk("hold_lat", 32'(lat), 32'd9);
      chk("hold_busy_cyc", 32'(bcnt), 32'd8);
      bus.op       = OP_ADD;
      bus.a        = 8'h01;
      bus.b        = 8'h01;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk("hold_res", 32'(bus.result), 32'hF1);
         chk("hold_ov", 32'(bus.out_valid), 32'd1);
         chk("hold_rdy", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      finish_op("hold");
      @(posedge clk);
      #1;
      chk("hold_ignored_ov", 32'(bus.out_valid), 32'd0);
      chk("hold_ignored_res", 32'(bus.result), 32'hF1);

      // Reset four cycles into a multiply
      bus.op       = OP_MUL;
      bus.a        = 8'h33;
      bus.b        = 8'h07;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_res", 32'(bus.result), 32'd0);
      chk("mid_rst_flags", 32'(bus.flags), 32'd0);
      chk("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rel_rdy", 32'(bus.in_ready), 32'd1);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid || bus.busy) seen++;
      end
      chk("mid_no_partial", 32'(seen), 32'd0);

      run_op(OP_ADD, 8'h02, 8'h03, lat, bcnt);
      chk("post_lat", 32'(lat), 32'd1);
      chk("post_res", 32'(bus.result), 32'h05);
      chk("post_flags", 32'(bus.flags), 32'h00);
      finish_op("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
